// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream writer for the core's program-memory load port.
// Frame format: SYNC_BYTE, length L (1..2**ADDR_SIZE), L payload bytes, checksum C
// such that (sum of payload + C) mod 256 == 0. Payload byte k is written to ADDR k.
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready are both
// high. The source holds in_data stable while in_valid is high and in_ready is low.
// in_ready drops only for the single DONE cycle.
module prog_loader #(
    parameter int         DATA_SIZE = 8,
    parameter int         ADDR_SIZE = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    input  logic                 abort,
    output logic                 W,
    output logic [ADDR_SIZE-1:0] ADDR,
    output logic [DATA_SIZE-1:0] DATA_WR,
    output logic                 OVERWRITE,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int MAX_LEN = 1 << ADDR_SIZE;
    localparam int CW      = ADDR_SIZE + 1;   // wide enough to hold MAX_LEN itself

    // A failed length or checksum is reported and the FSM returns to IDLE on the
    // same edge, so the error condition needs no state of its own.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] idx;
    logic [CW-1:0] len;
    logic [7:0]    sum;
    logic          accept;

    assign accept    = in_valid && in_ready;
    assign OVERWRITE = busy;

    // Frame FSM with registered write port, status flags and ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            idx      <= '0;
            len      <= '0;
            sum      <= '0;
            in_ready <= 1'b1;
            W        <= 1'b0;
            ADDR     <= '0;
            DATA_WR  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            W    <= 1'b0;
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                // Abort wins over any byte offered this cycle; no write is issued.
                state    <= S_IDLE;
                err      <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept && in_data == SYNC_BYTE) begin
                            state <= S_LEN;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            idx   <= '0;
                            sum   <= '0;
                        end
                    end
                    S_LEN: begin
                        if (accept) begin
                            if (in_data == 8'h00 || int'(in_data) > MAX_LEN) begin
                                state <= S_IDLE;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                len   <= in_data[CW-1:0];
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            W       <= 1'b1;
                            ADDR    <= idx[ADDR_SIZE-1:0];
                            DATA_WR <= in_data[DATA_SIZE-1:0];
                            idx     <= idx + CW'(1);
                            sum     <= sum + in_data;
                            if (idx + CW'(1) == len) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (accept) begin
                            busy <= 1'b0;
                            if (8'(sum + in_data) == 8'h00) begin
                                state    <= S_DONE;
                                done     <= 1'b1;
                                in_ready <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                err   <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end
                    default: begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: per-cycle vector table, hand-written abort/reset/length
// sequences, and randomized frames checked against a frame-level reference model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       abort = 1'b0;
    logic       in_ready, W, OVERWRITE, busy, done, err;
    logic [3:0] ADDR;
    logic [7:0] DATA_WR;

    int  checks = 0;
    int  errors = 0;
    int  done_cnt = 0;
    int  exp_done = 0;
    bit  exp_err = 1'b0;
    bit  mon_en = 1'b0;
    bit  gap_en = 1'b0;
    logic [11:0] exp_q[$];   // {addr, data} of each expected program-memory write

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       a;
        logic       ew;
        logic [3:0] ea;
        logic [7:0] ed;
        logic       edone;
        logic       eerr;
        logic       ebusy;
        logic       erdy;
    } vec_t;
    vec_t tv[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    prog_loader #(.DATA_SIZE(8), .ADDR_SIZE(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .abort(abort), .W(W), .ADDR(ADDR), .DATA_WR(DATA_WR),
        .OVERWRITE(OVERWRITE), .busy(busy), .done(done), .err(err)
    );

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (W) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected act=%0h@%0h exp=none", DATA_WR, ADDR);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    if ({ADDR, DATA_WR} !== e) begin
                        errors++;
                        $display("FAIL write act=%0h@%0h exp=%0h@%0h", DATA_WR, ADDR, e[7:0], e[11:8]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    // Offers b and returns right after the rising edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gap_en && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout act=in_ready_low exp=in_ready_high");
        end
        @(posedge clk);
    endtask

    // Reference model at frame level: a legal length writes payload k to ADDR k,
    // then the checksum decides between a done pulse and a sticky error.
    task automatic send_frame(input logic [7:0] l, input bit good_cs);
        logic [7:0] s, b, c;
        bit len_ok;
        len_ok = (l != 8'd0) && (l <= 8'd16);
        send_byte(8'hA5);
        send_byte(l);
        if (!len_ok) begin
            exp_err = 1'b1;
        end else begin
            s = 8'h00;
            for (int i = 0; i < int'(l); i++) begin
                b = 8'($urandom);
                exp_q.push_back({4'(i), b});
                s = s + b;
                send_byte(b);
            end
            c = 8'(0) - s;
            if (!good_cs) c = c + 8'($urandom_range(1, 255));
            send_byte(c);
            if (good_cs) begin
                exp_done++;
                exp_err = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
        end
        idle(2);
        check("frame_err", 32'(err), 32'(exp_err));
        check("frame_busy", 32'(busy), 32'd0);
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic ew,
                                input logic [3:0] ea, input logic [7:0] ed,
                                input logic edone, input logic eerr,
                                input logic ebusy, input logic erdy);
        vec_t t;
        t.v = v; t.d = d; t.a = 1'b0; t.ew = ew; t.ea = ea; t.ed = ed;
        t.edone = edone; t.eerr = eerr; t.ebusy = ebusy; t.erdy = erdy;
        return t;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] pay;
        int r;

        // Reset state
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_outputs", 32'({W, done, err, busy, OVERWRITE, in_ready}), 32'b000001);
        check("rst_addr_data", 32'({ADDR, DATA_WR}), 32'd0);

        // Per-cycle vectors; expectations are outputs just after the edge.
        //              v  data    W  addr data  done err busy rdy
        tv.push_back(mk(1, 8'hA5, 0, 4'd0, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h03, 0, 4'd0, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h11, 1, 4'd0, 8'h11, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h22, 1, 4'd1, 8'h22, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h33, 1, 4'd2, 8'h33, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h9A, 0, 4'd0, 8'h00, 1, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0, 1));
        tv.push_back(mk(1, 8'hA5, 0, 4'd0, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h02, 0, 4'd0, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h10, 1, 4'd0, 8'h10, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h20, 1, 4'd1, 8'h20, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h00, 0, 4'd0, 8'h00, 0, 1, 0, 1));
        tv.push_back(mk(0, 8'h00, 0, 4'd0, 8'h00, 0, 1, 0, 1));
        tv.push_back(mk(1, 8'h00, 0, 4'd0, 8'h00, 0, 1, 0, 1));
        tv.push_back(mk(1, 8'hFF, 0, 4'd0, 8'h00, 0, 1, 0, 1));
        tv.push_back(mk(1, 8'h5A, 0, 4'd0, 8'h00, 0, 1, 0, 1));
        tv.push_back(mk(1, 8'hA5, 0, 4'd0, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h01, 0, 4'd0, 8'h00, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h7F, 1, 4'd0, 8'h7F, 0, 0, 1, 1));
        tv.push_back(mk(1, 8'h81, 0, 4'd0, 8'h00, 1, 0, 0, 0));
        tv.push_back(mk(0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0, 1));

        foreach (tv[i]) begin
            logic [5:0] act, exp;
            @(negedge clk);
            in_valid = tv[i].v;
            in_data  = tv[i].d;
            abort    = tv[i].a;
            @(posedge clk);
            #1;
            act = {W, done, err, busy, OVERWRITE, in_ready};
            exp = {tv[i].ew, tv[i].edone, tv[i].eerr, tv[i].ebusy, tv[i].ebusy, tv[i].erdy};
            checks++;
            if (act !== exp || (tv[i].ew && {ADDR, DATA_WR} !== {tv[i].ea, tv[i].ed})) begin
                errors++;
                $display("FAIL vec%0d act=%b/%0h@%0h exp=%b/%0h@%0h", i, act, DATA_WR, ADDR,
                         exp, tv[i].ed, tv[i].ea);
            end
        end
        idle(1);
        mon_en = 1'b1;

        // Length bounds
        send_frame(8'd0, 1'b1);
        send_frame(8'd17, 1'b1);
        send_frame(8'd16, 1'b1);
        check("len16_writes_left", 32'(exp_q.size()), 32'd0);

        // Abort together with the third payload byte
        send_byte(8'hA5);
        send_byte(8'h04);
        exp_q.push_back({4'd0, 8'h01});
        exp_q.push_back({4'd1, 8'h02});
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h03;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        check("abort_flags", 32'({W, err, busy, OVERWRITE, in_ready}), 32'b01001);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        send_byte(8'h03);
        #1;
        check("abort_idle_busy", 32'({busy, err}), 32'b01);
        idle(2);
        check("abort_writes_left", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of DATA with in_valid held high
        send_byte(8'hA5);
        send_byte(8'h08);
        for (int i = 0; i < 3; i++) begin
            pay = 8'($urandom);
            if (i < 2) exp_q.push_back({4'(i), pay});
            send_byte(pay);
        end
        in_data = 8'h00;
        #2;
        check("pre_reset_w", 32'(W), 32'd1);
        rstn = 1'b0;
        #1;
        check("reset_async", 32'({W, busy, OVERWRITE, in_ready, done}), 32'b00010);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("reset_writes_left", 32'(exp_q.size()), 32'd0);
        exp_err = 1'b0;
        send_frame(8'd3, 1'b1);

        // Randomized frames
        gap_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    pay = 8'($urandom);
                    if (pay == 8'hA5) pay = 8'h5A;
                    send_byte(pay);
                end
            end
            r = $urandom_range(0, 9);
            if (r == 0) send_frame(8'd0, 1'b1);
            else if (r == 1) send_frame(8'($urandom_range(17, 255)), 1'b1);
            else if (r < 4) send_frame(8'($urandom_range(1, 16)), 1'b0);
            else send_frame(8'($urandom_range(1, 16)), 1'b1);
        end
        idle(3);

        // Final report
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("writes_left", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
